// File: rtl/mult_div_unit_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mult_div_unit_if : controller <-> mult/div unit handshake and HI/LO bus
// Revision : 1.0
// -----------------------------------------------------------------------------
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             mdstartE;
   logic [1:0]       mdopE;
   logic [WIDTH-1:0] srcaE;
   logic [WIDTH-1:0] srcbE;
   logic             hilowriteE;
   logic             hiloselE;
   logic [1:0]       hilodisableE;
   logic             mdrunE;
   logic [WIDTH-1:0] hiE;
   logic [WIDTH-1:0] loE;

   modport master (
      output mdstartE, mdopE, srcaE, srcbE, hilowriteE, hiloselE, hilodisableE,
      input  mdrunE, hiE, loE
   );

   modport slave (
      input  mdstartE, mdopE, srcaE, srcbE, hilowriteE, hiloselE, hilodisableE,
      output mdrunE, hiE, loE
   );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mult_div_unit : iterative signed/unsigned multiply/divide with HI/LO registers
// Revision : 1.0
// -----------------------------------------------------------------------------
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  wire logic      clk,
   input  wire logic      reset,
   mult_div_unit_if.slave md
);
   localparam int            CW     = $clog2(WIDTH);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [CW-1:0]    r_count;
   logic [1:0]       r_op;
   logic             r_sign_a;
   logic             r_sign_b;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc_hi;
   logic [WIDTH-1:0] r_acc_lo;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   // Operand capture: magnitudes for signed ops, raw values otherwise
   logic             w_start;
   logic             w_sign_a;
   logic             w_sign_b;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;

   assign w_start  = (r_state == S_IDLE) && md.mdstartE;
   assign w_sign_a = md.mdopE[0] & md.srcaE[WIDTH-1];
   assign w_sign_b = md.mdopE[0] & md.srcbE[WIDTH-1];
   assign w_mag_a  = w_sign_a ? -md.srcaE : md.srcaE;
   assign w_mag_b  = w_sign_b ? -md.srcbE : md.srcbE;

   // Multiply step: conditional add then shift the 2*WIDTH accumulator right
   logic [WIDTH-1:0] w_addend;
   logic [WIDTH:0]   w_sum;

   assign w_addend = r_acc_lo[0] ? r_a : '0;
   assign w_sum    = {1'b0, r_acc_hi} + {1'b0, w_addend};

   // Divide step: trial subtraction, one guard bit above the remainder width
   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_diff;
   logic             w_qbit;

   assign w_shift = {r_rem, r_acc_lo[WIDTH-1]};
   assign w_diff  = w_shift - {2'b00, r_b};
   assign w_qbit  = ~w_diff[WIDTH+1];

   // Sign correction applied in FIX
   logic               w_neg;
   logic               w_div0;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quot_fix;
   logic [WIDTH-1:0]   w_rem_fix;
   logic [WIDTH-1:0]   w_raw_a;

   assign w_neg      = r_sign_a ^ r_sign_b;
   assign w_div0     = (r_b == '0);
   assign w_prod     = {r_acc_hi, r_acc_lo};
   assign w_prod_fix = w_neg ? -w_prod : w_prod;
   assign w_quot_fix = w_neg ? -r_acc_lo : r_acc_lo;
   assign w_rem_fix  = r_sign_a ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
   assign w_raw_a    = r_sign_a ? -r_a : r_a;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (md.mdstartE) w_state_nxt = S_CALC;
         S_CALC:  if (r_count == C_LAST) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count  <= '0;
         r_op     <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_rem    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else if (w_start) begin
         r_count  <= '0;
         r_op     <= md.mdopE;
         r_sign_a <= w_sign_a;
         r_sign_b <= w_sign_b;
         r_a      <= w_mag_a;
         r_b      <= w_mag_b;
         r_acc_hi <= '0;
         r_acc_lo <= md.mdopE[1] ? w_mag_a : w_mag_b;
         r_rem    <= '0;
      end else if (r_state == S_CALC) begin
         r_count <= r_count + 1'b1;
         if (r_op[1]) begin
            r_rem    <= w_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_qbit};
         end else begin
            r_acc_hi <= w_sum[WIDTH:1];
            r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
         end
      end else if (r_state == S_FIX) begin
         if (!r_op[1]) begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
         end else if (w_div0) begin
            r_hi <= w_raw_a;
            r_lo <= '1;
         end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
         end
      end else if (r_state == S_IDLE && md.hilowriteE) begin
         if (md.hiloselE && !md.hilodisableE[1])  r_hi <= md.srcaE;
         if (!md.hiloselE && !md.hilodisableE[0]) r_lo <= md.srcaE;
      end
   end

   assign md.mdrunE = (r_state != S_IDLE);
   assign md.hiE    = r_hi;
   assign md.loE    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_mult_div_unit : directed + randomized checks against an arithmetic model
// Revision : 1.0
// -----------------------------------------------------------------------------
module tb_mult_div_unit;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   always #5 clk = ~clk;

   mult_div_unit_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (bus.slave)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Architectural result {HI, LO} from plain arithmetic
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] ua, ub, res;
      longint      sa, sb, q, r;
      ua = {32'd0, a};
      ub = {32'd0, b};
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         2'b00: res = ua * ub;
         2'b01: res = sa * sb;
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else if (op == 2'b10) res = {a % b, a / b};
            else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 6))
         0:       v = 32'd0;
         1:       v = 32'h8000_0000;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'($urandom_range(0, 20));
         4:       v = -32'($urandom_range(1, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit wr_same, input bit interfere);
      logic [63:0] r;
      int          n;
      bit          hold_ok;
      string       tag;
      tag = $sformatf("op%0d %h,%h", op, a, b);
      r   = model(op, a, b);
      bus.mdstartE     = 1'b1;
      bus.mdopE        = op;
      bus.srcaE        = a;
      bus.srcbE        = b;
      bus.hilowriteE   = wr_same;
      bus.hiloselE     = 1'($urandom_range(0, 1));
      bus.hilodisableE = 2'b00;
      tick();
      bus.mdstartE   = 1'b0;
      bus.hilowriteE = 1'b0;
      n       = 0;
      hold_ok = 1'b1;
      while (bus.mdrunE === 1'b1 && n < 60) begin
         if (bus.hiE !== exp_hi || bus.loE !== exp_lo) hold_ok = 1'b0;
         if (interfere && n == 4) begin
            bus.mdstartE     = 1'b1;
            bus.mdopE        = 2'($urandom);
            bus.srcaE        = $urandom;
            bus.srcbE        = $urandom;
            bus.hilowriteE   = 1'b1;
            bus.hiloselE     = 1'b1;
            bus.hilodisableE = 2'b00;
         end else begin
            bus.mdstartE   = 1'b0;
            bus.hilowriteE = 1'b0;
         end
         n++;
         tick();
      end
      bus.mdstartE   = 1'b0;
      bus.hilowriteE = 1'b0;
      chk({tag, " busy_cycles"}, 64'(n), 64'd33);
      chk({tag, " hilo_hold"}, 64'(hold_ok), 64'd1);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      chk({tag, " hi"}, 64'(bus.hiE), 64'(exp_hi));
      chk({tag, " lo"}, 64'(bus.loE), 64'(exp_lo));
   endtask

   task automatic hilo_write(input bit sel, input logic [1:0] dis, input logic [31:0] d);
      bus.hilowriteE   = 1'b1;
      bus.hiloselE     = sel;
      bus.hilodisableE = dis;
      bus.srcaE        = d;
      tick();
      bus.hilowriteE = 1'b0;
      if (sel && !dis[1])  exp_hi = d;
      if (!sel && !dis[0]) exp_lo = d;
      chk($sformatf("mt sel%0d dis%b hi", sel, dis), 64'(bus.hiE), 64'(exp_hi));
      chk($sformatf("mt sel%0d dis%b lo", sel, dis), 64'(bus.loE), 64'(exp_lo));
   endtask

   initial begin
      reset            = 1'b1;
      bus.mdstartE     = 1'b0;
      bus.mdopE        = 2'b00;
      bus.srcaE        = '0;
      bus.srcbE        = '0;
      bus.hilowriteE   = 1'b0;
      bus.hiloselE     = 1'b0;
      bus.hilodisableE = 2'b00;
      exp_hi           = '0;
      exp_lo           = '0;
      tick();
      tick();
      chk("reset mdrunE", 64'(bus.mdrunE), 64'd0);
      chk("reset hiE", 64'(bus.hiE), 64'd0);
      chk("reset loE", 64'(bus.loE), 64'd0);
      reset = 1'b0;
      tick();

      // Directed corner operations, issued back to back
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk("multu max literal", {32'd0, bus.hiE}, 64'h0000_0000_FFFF_FFFE);
      run_op(2'b01, -32'd3, 32'd5, 1'b0, 1'b0);
      run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      chk("mult minint literal", {bus.hiE, bus.loE}, 64'h4000_0000_0000_0000);
      run_op(2'b11, -32'd7, 32'd2, 1'b0, 1'b0);
      run_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk("div overflow literal", {bus.hiE, bus.loE}, 64'h0000_0000_8000_0000);
      run_op(2'b10, 32'd100, 32'd0, 1'b0, 1'b0);
      run_op(2'b11, -32'd5, 32'd0, 1'b0, 1'b0);

      // Start and write requests while busy are ignored
      run_op(2'b10, 32'd12345, 32'd97, 1'b0, 1'b1);
      hilo_write(1'b1, 2'b10, 32'h1234);
      hilo_write(1'b0, 2'b00, 32'h1234);
      hilo_write(1'b1, 2'b00, 32'hCAFE_F00D);
      hilo_write(1'b0, 2'b01, 32'hDEAD_BEEF);

      // Start wins over a same-cycle write
      run_op(2'b01, 32'd9, -32'd4, 1'b1, 1'b0);

      // Reset in the middle of a MULT
      bus.mdstartE = 1'b1;
      bus.mdopE    = 2'b01;
      bus.srcaE    = 32'd123;
      bus.srcbE    = 32'd456;
      tick();
      bus.mdstartE = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      chk("midreset mdrunE", 64'(bus.mdrunE), 64'd0);
      chk("midreset hiE", 64'(bus.hiE), 64'd0);
      chk("midreset loE", 64'(bus.loE), 64'd0);
      run_op(2'b00, 32'd6, 32'd7, 1'b0, 1'b0);

      // Randomized operations and HI/LO writes
      for (int i = 0; i < 24; i++) begin
         logic [1:0] op;
         logic [31:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = pick();
         b  = pick();
         run_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0)
            hilo_write(1'($urandom_range(0, 1)), 2'($urandom), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide engine that serves as the responder for the pipeline controller's mult/div start, HI/LO-write and run signals. It accepts MULT, MULTU, DIV and DIVU operations in the execute stage and computes one result bit per cycle. It holds the architectural HI/LO registers and drives the busy flag the controller uses to stall and to gate HI/LO access. It also services MTHI/MTLO writes.

## Interface
Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mdstartE  in  1  start request for a mult/div instruction in E.
- mdopE  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- srcaE  in  WIDTH  rs operand: multiplicand or dividend. Also the MTHI/MTLO data.
- srcbE  in  WIDTH  rt operand: multiplier or divisor.
- hilowriteE  in  1  MTHI/MTLO write request.
- hiloselE  in  1  write target: 1 selects HI, 0 selects LO.
- hilodisableE  in  2  write suppress: bit 1 blocks a HI write, bit 0 blocks a LO write.
- mdrunE  out  1  unit busy.
- hiE  out  WIDTH  current HI register.
- loE  out  WIDTH  current LO register.

## Operation
- States:
  - IDLE.
  - CALC: 32 iterations, 5-bit count.
  - FIX: sign correction and writeback.
- mdrunE = (state != IDLE). It is decoded from registered state, with no combinational path from inputs.
- Start acceptance:
  - In IDLE, mdstartE=1 latches mdopE, |srcaE| and |srcbE| (magnitudes for signed ops, raw values for unsigned), plus both operand signs. State goes to CALC with count=0.
- Multiply:
  - Shift-add on the 64-bit accumulator {acc_hi, acc_lo}, one multiplier bit per CALC cycle, LSB first.
- Divide:
  - Restoring division, one quotient bit per CALC cycle, MSB first.
  - Remainder register is WIDTH+1 bits.
- FIX:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ. The remainder takes the dividend's sign.
  - Write HI = product[63:32] or remainder; LO = product[31:0] or quotient. Return to IDLE.
- Divisor zero (DIV or DIVU): FIX writes LO=32'hFFFFFFFF and HI=raw srcaE as latched at start, with no sign fix. No exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (natural two's-complement wrap).
- MULT of 0x80000000 by 0x80000000 must give HI=0x40000000, LO=0. The magnitude datapath must not truncate.
- MTHI/MTLO:
  - Executes only in IDLE with hilowriteE=1: HI or LO (per hiloselE) ← srcaE, unless the matching hilodisableE bit is set.
- Simultaneous events:
  - mdstartE and hilowriteE in the same IDLE cycle: start wins and the write is dropped.
  - mdstartE while busy: ignored. The operation in flight is unaffected.
  - hilowriteE while busy: ignored.
- The controller must stall the pipeline on mdrunE. This unit does not queue requests.

## Timing
- Reset: state=IDLE, count=0, HI=0, LO=0, mdrunE=0, hiE=0, loE=0. All internal operand and accumulator registers are cleared.
- Start latency:
  - Start sampled at the edge ending cycle 0.
  - mdrunE=1 in cycles 1..33: CALC in cycles 1..32, FIX in cycle 33.
  - HI/LO update at the edge ending cycle 33.
  - New values are visible, and mdrunE=0, in cycle 34.
- Back-to-back: a new start can be accepted in cycle 34, the first IDLE cycle.
- MTHI/MTLO: a write sampled in cycle n is visible on hiE/loE in cycle n+1.
- hiE and loE hold their old values throughout CALC and FIX. Intermediate results never appear on them.
- Reset asserted mid-operation: the next cycle is IDLE with HI=LO=0 and mdrunE=0. The in-flight result is discarded.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → mdrunE high for exactly 33 cycles. In cycle 34, HI=0xFFFFFFFE and LO=0x00000001.
- MULT −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064.
- Start DIVU; in cycle 5 pulse mdstartE with new operands and hilowriteE to HI → both ignored, and the original result lands in cycle 34. Then, in IDLE:
  - MTHI 0x1234 with hilodisableE=2'b10 → HI unchanged.
  - MTLO 0x1234 with hilodisableE=2'b00 → LO=0x1234 next cycle.
- Start MULT, assert reset in cycle 10 → next cycle HI=LO=0 and mdrunE=0. A subsequent MULTU 6×7 gives LO=42, HI=0 in cycle 34 after its start.
